// File: rtl/compressor_pkg.sv
// Shared LZRW1 types and constants used by the compressor/decompressor cores.
package compressor_pkg;

    localparam int LZRW1_MIN_LEN    = 3;
    localparam int LZRW1_HIST_DEPTH = 4096;

    typedef enum logic [1:0] {
        S_ITEM    = 2'd0,
        S_COPY_LO = 2'd1,
        S_COPY    = 2'd2,
        S_DONE    = 2'd3
    } lzrw1_state_e;

    // A decoded copy item: length 3..18 and a 12-bit backward offset.
    typedef struct packed {
        logic [4:0]  len;
        logic [11:0] off;
    } copy_item_t;

    // Split the two copy-item bytes into length and offset.
    function automatic copy_item_t decode_copy(input logic [7:0] hi, input logic [7:0] lo);
        copy_item_t c;
        c.len = {1'b0, hi[7:4]} + 5'(LZRW1_MIN_LEN);
        c.off = {hi[3:0], lo};
        return c;
    endfunction

endpackage

// File: rtl/lzrw1_history.sv
// History window for the LZRW1 decoder: one synchronous write port and one
// combinational read port, so a byte written on an edge is readable right after.
module lzrw1_history #(
    parameter int HIST_DEPTH = 4096,
    parameter int AW         = $clog2(HIST_DEPTH)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_r [HIST_DEPTH];

    // Store each decoded byte at the write pointer; contents survive reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/lzrw1_decompressor.sv
// Streaming LZRW1 decoder: literals and two-byte copy items in, one decoded
// byte per cycle out, with a power-of-two history window.
// Optional stream checking is built when LZRW1_DECOMP_CHECK_EN is defined.
module lzrw1_decompressor
    import compressor_pkg::*;
#(
    parameter int HIST_DEPTH = LZRW1_HIST_DEPTH,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_byte,
    input  logic             in_ctrl,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_byte,
    output logic             out_last,
    output logic             Done,
    output logic [CNT_W-1:0] out_count,
    output logic             err
);

    localparam int OFF_W = $clog2(HIST_DEPTH);

    lzrw1_state_e     state_r, state_next_s;
    logic [OFF_W-1:0] wr_r, src_r;
    logic [4:0]       rem_r;
    logic [7:0]       hi_r, out_byte_r, load_byte_s, hist_rdata_s;
    logic             last_pend_r, rdy_en_r, new_stream_r;
    logic             out_valid_r, out_last_r, done_r, done_next_s;
    logic [CNT_W-1:0] out_count_r;
    logic             free_s, hsk_s, accept_s, start_s, load_s, last_load_s;
    logic             lit_s, hi_s, lo_s, cpy_s;
    copy_item_t       item_s;

    // The output register can take a new byte when empty or being drained.
    // A stream's final byte blocks new items until it is handed off, so the
    // next stream cannot start before Done.
    assign free_s   = !out_valid_r || out_ready;
    assign hsk_s    = out_valid_r && out_ready;
    assign in_ready = rdy_en_r && free_s && !out_last_r &&
                      ((state_r == S_ITEM) || (state_r == S_COPY_LO));
    assign accept_s = in_valid && in_ready;
    assign start_s  = accept_s && new_stream_r;
    assign load_s   = lit_s || cpy_s;
    assign item_s   = decode_copy(hi_r, in_byte);

    lzrw1_history #(.HIST_DEPTH(HIST_DEPTH), .AW(OFF_W)) u_hist (
        .clock (clock),
        .we    (load_s),
        .waddr (wr_r),
        .wdata (load_byte_s),
        .raddr (src_r),
        .rdata (hist_rdata_s)
    );

    // Decode per-state action strobes.
    always_comb begin
        lit_s = 1'b0;
        hi_s  = 1'b0;
        lo_s  = 1'b0;
        cpy_s = 1'b0;
        case (state_r)
            S_ITEM: begin
                lit_s = accept_s && !in_ctrl;
                hi_s  = accept_s && in_ctrl;
            end
            S_COPY_LO: lo_s = accept_s;
            S_COPY:    cpy_s = free_s;
            S_DONE:    lit_s = 1'b0;
            default:   lit_s = 1'b0;
        endcase
    end

    // Select the byte entering the output register and whether it ends the stream.
    always_comb begin
        if (lit_s) begin
            load_byte_s = in_byte;
            last_load_s = in_last;
        end else begin
            load_byte_s = hist_rdata_s;
            last_load_s = last_pend_r && (rem_r == 5'd1);
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= S_ITEM;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_ITEM: begin
                if (hi_s) begin
                    state_next_s = S_COPY_LO;
                end else if (hsk_s && out_last_r) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_ITEM;
                end
            end
            S_COPY_LO: state_next_s = lo_s ? S_COPY : S_COPY_LO;
            S_COPY:    state_next_s = (cpy_s && (rem_r == 5'd1)) ? S_ITEM : S_COPY;
            S_DONE:    state_next_s = S_ITEM;
            default:   state_next_s = S_ITEM;
        endcase
    end

    // FSM output logic: Done is registered from the state being entered.
    always_comb begin
        if (state_next_s == S_DONE) begin
            done_next_s = 1'b1;
        end else begin
            done_next_s = 1'b0;
        end
    end

    // Datapath: output register, pointers, copy bookkeeping and stream counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_r  <= 1'b0;
            out_byte_r   <= 8'd0;
            out_last_r   <= 1'b0;
            done_r       <= 1'b0;
            out_count_r  <= '0;
            wr_r         <= '0;
            src_r        <= '0;
            rem_r        <= 5'd0;
            hi_r         <= 8'd0;
            last_pend_r  <= 1'b0;
            rdy_en_r     <= 1'b0;
            new_stream_r <= 1'b1;
        end else begin
            rdy_en_r <= 1'b1;
            done_r   <= done_next_s;
            if (load_s) begin
                out_valid_r <= 1'b1;
                out_byte_r  <= load_byte_s;
                out_last_r  <= last_load_s;
                wr_r        <= wr_r + 1'b1;
            end else if (hsk_s) begin
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
            end
            if (hi_s) begin
                hi_r <= in_byte;
            end
            if (lo_s) begin
                src_r       <= wr_r - OFF_W'(item_s.off);
                rem_r       <= item_s.len;
                last_pend_r <= in_last;
            end else if (cpy_s) begin
                src_r <= src_r + 1'b1;
                rem_r <= rem_r - 5'd1;
            end
            if (start_s) begin
                out_count_r <= '0;
            end else if (hsk_s && (out_count_r != {CNT_W{1'b1}})) begin
                out_count_r <= out_count_r + 1'b1;
            end
            if (state_r == S_DONE) begin
                new_stream_r <= 1'b1;
            end else if (accept_s) begin
                new_stream_r <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_byte  = out_byte_r;
    assign out_last  = out_last_r;
    assign Done      = done_r;
    assign out_count = out_count_r;

`ifdef LZRW1_DECOMP_CHECK_EN
    logic [OFF_W:0] dec_cnt_r;
    logic           err_r, err_hit_s;

    // Flag offsets of zero or reaching before the stream start, and in_last on a copy's first byte.
    always_comb begin
        if (hi_s && in_last) begin
            err_hit_s = 1'b1;
        end else if (lo_s && ((item_s.off == 12'd0) || (32'(item_s.off) > 32'(dec_cnt_r)))) begin
            err_hit_s = 1'b1;
        end else begin
            err_hit_s = 1'b0;
        end
    end

    // Track bytes decoded in this stream (saturating) and the sticky error.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dec_cnt_r <= '0;
            err_r     <= 1'b0;
        end else begin
            if (start_s) begin
                dec_cnt_r <= {{OFF_W{1'b0}}, load_s};
                err_r     <= err_hit_s;
            end else begin
                if (load_s && (dec_cnt_r != (OFF_W+1)'(HIST_DEPTH))) begin
                    dec_cnt_r <= dec_cnt_r + 1'b1;
                end
                if (err_hit_s) begin
                    err_r <= 1'b1;
                end
            end
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lzrw1_decompressor.sv
// Directed self-checking bench for lzrw1_decompressor.
module tb_lzrw1_decompressor;

`ifdef LZRW1_DECOMP_CHECK_EN
    localparam logic CHECK_ON = 1'b1;
`else
    localparam logic CHECK_ON = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_byte;
    logic        in_ctrl;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;
    logic        Done;
    logic [15:0] out_count;
    logic        err;

    logic hold_mode, toggle_mode, tog;
    assign out_ready = hold_mode ? 1'b0 : (toggle_mode ? tog : 1'b1);

    int pass_cnt = 0;
    int total_cnt = 0;

    // Monitor state (written only by the monitor process)
    int         cyc = 0;
    logic [7:0] byte_q[$];
    logic       last_q[$];
    int         hcyc_q[$];
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         rdy_seen = 0;

    lzrw1_decompressor dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_byte   (in_byte),
        .in_ctrl   (in_ctrl),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_last  (out_last),
        .Done      (Done),
        .out_count (out_count),
        .err       (err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        tog = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            tog = ~tog;
        end
    end

    // Sample mid-cycle: record handshakes, Done pulses and in_ready activity.
    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            if (out_valid && out_ready) begin
                byte_q.push_back(out_byte);
                last_q.push_back(out_last);
                hcyc_q.push_back(cyc);
            end
            if (Done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (in_ready) rdy_seen++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] b, input logic c, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_byte  = b;
        in_ctrl  = c;
        in_last  = l;
        @(negedge clock);
        while (!in_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) check("send_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #2;
        in_valid = 1'b0;
        in_ctrl  = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (done_cnt == d0) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_stream(input string tag, input int base, input logic [7:0] exp_q[$]);
        int n;
        n = exp_q.size();
        check({tag, "_len"}, 32'(byte_q.size() - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < byte_q.size()) begin
                check({tag, "_byte"}, 32'(byte_q[base + i]), 32'(exp_q[i]));
                check({tag, "_last"}, 32'(last_q[base + i]), 32'(i == n - 1));
            end
        end
    endtask

    initial begin
        logic [7:0] exp_q[$];
        int base, d0, mark;

        reset = 1'b0;
        in_valid = 1'b0; in_byte = 8'd0; in_ctrl = 1'b0; in_last = 1'b0;
        hold_mode = 1'b0; toggle_mode = 1'b0;

        // Reset values
        repeat (3) @(negedge clock);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_done",      32'(Done),      32'd0);
        check("rst_count",     32'(out_count), 32'd0);
        check("rst_err",       32'(err),       32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        reset = 1'b1;
        @(posedge clock);
        #2;

        // Literals A,B,C
        base = byte_q.size(); d0 = done_cnt;
        send(8'h41, 1'b0, 1'b0);
        send(8'h42, 1'b0, 1'b0);
        send(8'h43, 1'b0, 1'b1);
        wait_done(d0);
        check("abc_count", 32'(out_count), 32'd3);
        check("abc_err", 32'(err), 32'd0);
        exp_q = '{8'h41, 8'h42, 8'h43};
        check_stream("abc", base, exp_q);
        if (byte_q.size() >= base + 3) begin
            check("abc_consecutive", 32'(hcyc_q[base + 2] - hcyc_q[base]), 32'd2);
            check("abc_done_timing", 32'(done_cyc - hcyc_q[base + 2]), 32'd1);
        end
        @(negedge clock);
        check("abc_done_pulse", 32'(Done), 32'd0);
        @(posedge clock); #2;

        // Overlapping copy, off=2 len=3
        base = byte_q.size(); d0 = done_cnt;
        send(8'h61, 1'b0, 1'b0);
        send(8'h62, 1'b0, 1'b0);
        send(8'h00, 1'b1, 1'b0);
        send(8'h02, 1'b0, 1'b1);
        wait_done(d0);
        check("ov_count", 32'(out_count), 32'd5);
        check("ov_err", 32'(err), 32'd0);
        exp_q = '{8'h61, 8'h62, 8'h61, 8'h62, 8'h61};
        check_stream("ov", base, exp_q);
        @(posedge clock); #2;

        // Maximum length copy, off=1
        base = byte_q.size(); d0 = done_cnt;
        send(8'h5A, 1'b0, 1'b0);
        send(8'hF0, 1'b1, 1'b0);
        send(8'h01, 1'b0, 1'b1);
        wait_done(d0);
        check("max_count", 32'(out_count), 32'd19);
        exp_q.delete();
        for (int i = 0; i < 19; i++) exp_q.push_back(8'h5A);
        check_stream("max", base, exp_q);
        if (byte_q.size() >= base + 19)
            check("max_throughput", 32'(hcyc_q[base + 18] - hcyc_q[base + 1]), 32'd17);
        @(posedge clock); #2;

        // Overlapping copy with out_ready toggling
        toggle_mode = 1'b1;
        base = byte_q.size(); d0 = done_cnt;
        send(8'h61, 1'b0, 1'b0);
        send(8'h62, 1'b0, 1'b0);
        send(8'h00, 1'b1, 1'b0);
        send(8'h02, 1'b0, 1'b1);
        mark = rdy_seen;
        wait_done(d0);
        check("tog_in_ready_low", 32'(rdy_seen - mark), 32'd0);
        check("tog_count", 32'(out_count), 32'd5);
        exp_q = '{8'h61, 8'h62, 8'h61, 8'h62, 8'h61};
        check_stream("tog", base, exp_q);
        toggle_mode = 1'b0;
        @(posedge clock); #2;

        // Zero-offset copy as the first item of a stream
        base = byte_q.size(); d0 = done_cnt;
        send(8'h00, 1'b1, 1'b0);
        send(8'h00, 1'b0, 1'b1);
        wait_done(d0);
        check("zoff_err", 32'(err), 32'(CHECK_ON));
        check("zoff_count", 32'(out_count), 32'd3);
        check("zoff_len", 32'(byte_q.size() - base), 32'd3);
        @(negedge clock);
        check("zoff_err_sticky", 32'(err), 32'(CHECK_ON));
        @(posedge clock); #2;
        base = byte_q.size(); d0 = done_cnt;
        send(8'h33, 1'b0, 1'b1);
        check("zoff_err_clear", 32'(err), 32'd0);
        wait_done(d0);
        exp_q = '{8'h33};
        check_stream("after_err", base, exp_q);
        check("after_err_count", 32'(out_count), 32'd1);
        @(posedge clock); #2;

        // Reset mid-copy with rem=5 held by back-pressure
        send(8'h77, 1'b0, 1'b0);
        send(8'h50, 1'b1, 1'b0);
        send(8'h01, 1'b0, 1'b0);
        repeat (3) @(posedge clock);
        #2;
        hold_mode = 1'b1;
        @(negedge clock);
        check("mid_out_valid", 32'(out_valid), 32'd1);
        check("mid_in_ready", 32'(in_ready), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready",  32'(in_ready),  32'd0);
        check("arst_count",     32'(out_count), 32'd0);
        @(negedge clock);
        #3;
        reset = 1'b1;
        hold_mode = 1'b0;
        @(posedge clock); #2;
        base = byte_q.size(); d0 = done_cnt;
        send(8'h11, 1'b0, 1'b1);
        wait_done(d0);
        exp_q = '{8'h11};
        check_stream("post_rst", base, exp_q);
        check("post_rst_count", 32'(out_count), 32'd1);
        check("post_rst_err", 32'(err), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/lzrw1_decompressor.md
# lzrw1_decompressor

Streaming LZRW1 decoder that is the receive-side counterpart of the compressor core. It consumes the compressed byte stream (literal bytes and two-byte copy items, each tagged by its control-word bit) and reconstructs the original byte stream, one byte per cycle. It keeps a 4096-byte history window. It sits between the emulation transactor and the compare logic, so round-trip compress/decompress checks can run entirely in hardware.

## Interface
Parameters:
- HIST_DEPTH, 4096, history window size in bytes; power of two; offset width is log2(HIST_DEPTH).
- CNT_W, 16, width of the output byte counter.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  compressed byte present.
- in_ready  out  1  decoder accepts the byte this cycle.
- in_byte  in  8  compressed byte.
- in_ctrl  in  1  control bit: 1 marks the first byte of a copy item; ignored on a copy item's second byte.
- in_last  in  1  final item of the stream; sampled on a literal, or on a copy item's second byte.
- out_valid  out  1  decoded byte present.
- out_ready  in  1  sink accepts the decoded byte.
- out_byte  out  8  decoded byte.
- out_last  out  1  final decoded byte of the stream.
- Done  out  1  one-cycle pulse on stream completion.
- out_count  out  CNT_W  decoded bytes in the current stream.
- err  out  1  sticky malformed-stream flag.

## Operation
- Reset values:
  - All outputs are 0; in_ready is 0 during reset.
  - State is S_ITEM; the write pointer is 0.
  - History contents are not cleared.
- States:
  - S_ITEM: accept an item byte. A literal (in_ctrl=0) loads out_byte, is written to history[wr], wr increments, and the state stays S_ITEM. A copy (in_ctrl=1) latches the byte as hi and goes to S_COPY_LO.
  - S_COPY_LO: accept lo.
    - len = hi[7:4] + 3 (range 3..18).
    - off = {hi[3:0], lo}.
    - src = wr − off, modulo HIST_DEPTH.
    - rem = len; go to S_COPY.
  - S_COPY: each cycle the output register is free, load out_byte from history[src] and write it to history[wr]. Then src++, wr++, rem--. When rem reaches 0, go to S_ITEM.
  - S_DONE: one cycle. Pulse Done, then return to S_ITEM.
- Output register is free when !out_valid or out_ready.
  - in_ready = free AND state is S_ITEM or S_COPY_LO.
  - In S_COPY, no advance occurs while the register is not free; state, src and rem hold.
- Overlapping copies (off < len) must replicate correctly. The history read is combinational, so a byte written on the previous edge is readable.
- A new stream starts on the first item accepted after Done or reset. At that point out_count and err clear, and wr is not reset.
- out_count increments on each output handshake and saturates at all-ones.
- out_last is set with the final byte of the item carrying in_last.
- All pointer arithmetic is modulo HIST_DEPTH and wraps silently.

## Timing
- Literal accepted at edge t: out_valid is high after edge t.
- Copy lo accepted at edge t: the first copy byte is loaded at edge t+1. A copy costs len+1 cycles of input stall.
- With out_ready held high, throughput is 1 decoded byte per cycle.
- Done is asserted in the cycle after the output handshake of the out_last byte.
- Reset asserted mid-item: all state is abandoned immediately; in_ready and out_valid drop asynchronously.

## Configuration
- LZRW1_DECOMP_CHECK_EN defined:
  - err sets when off==0, or when off > bytes decoded so far in the stream (the compared value saturates at HIST_DEPTH).
  - err also sets when in_last arrives on a copy item's first byte.
  - The copy still executes as specified.
- Macro undefined: err is tied to 0 and no check logic is built.

## Structure
- compressor_pkg additions:
  - LZRW1_MIN_LEN = 3.
  - LZRW1_HIST_DEPTH = 4096.
  - State enum: S_ITEM, S_COPY_LO, S_COPY, S_DONE.
  - Struct copy_item_t {len, off}.
- Sub-module lzrw1_history: HIST_DEPTH×8 storage, one synchronous write port, one asynchronous read port.

## Test plan
- Literals 0x41,0x42,0x43 with in_last on the last one, out_ready=1:
  - Output is A,B,C on consecutive cycles with out_last on C.
  - Done pulses one cycle later; out_count=3.
- Literals 0x61,0x62, then copy hi=0x00 lo=0x02: output is a,b,a,b,a after the literals (len 3 plus overlap).
- Literal 0x5A, then copy hi=0xF0 lo=0x01: 18 bytes of 0x5A are produced (maximum len, off=1 overlap).
- Same as the second scenario with out_ready toggling every other cycle: identical byte sequence, no drops or duplicates, in_ready low throughout S_COPY.
- With CHECK_EN, copy hi=0x00 lo=0x00 as the first item: err=1 stays set until the next stream's first accept. Without CHECK_EN, err stays 0.
- Reset asserted mid-copy with rem=5: out_valid and in_ready are 0 immediately. After release, the literal 0x11 decodes correctly with out_count=1.
